// File: rtl/usb_pkg.sv
// Shared definitions for the USB token path (receiver now, transmitter later).
// Holds the token FSM state type, SYNC/field-length constants, CRC5 constants,
// the token PID codes and the single-bit CRC5 update step.
package usb_pkg;

  typedef enum logic [2:0] {
    TOK_IDLE,
    TOK_PID,
    TOK_ADDR,
    TOK_ENDP,
    TOK_CRC,
    TOK_WAIT_EOP
  } tok_state_e;

  // SYNC as decoded bits, bit[0] arrives first: seven 0s then a 1.
  localparam logic [7:0] USB_SYNC = 8'b1000_0000;

  localparam int PID_BITS  = 8;
  localparam int ADDR_BITS = 7;
  localparam int ENDP_BITS = 4;
  localparam int CRC5_BITS = 5;

  localparam logic [4:0] CRC5_POLY          = 5'b00101;
  localparam logic [4:0] CRC5_INIT          = 5'b11111;
  localparam logic [4:0] USB_CRC5_RESIDUAL  = 5'b01100;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;

  // One serial CRC5 step: the incoming bit is folded in at the register MSB.
  function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[4];
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
  endfunction

endpackage

// File: rtl/usb_crc5.sv
// Serial USB CRC5 register: clr presets to all-ones, en folds in one bit.
// Latency: updated value visible the cycle after clr/en.
// Backpressure: none; caller qualifies each bit with en.
module usb_crc5
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [4:0] crc
);

  // Preset wins over update so a new packet always starts from all-ones.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      crc <= CRC5_INIT;
    end else if (clr) begin
      crc <= CRC5_INIT;
    end else if (en) begin
      crc <= crc5_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/usb_token_rx.sv
// USB token receiver: SYNC hunt, PID/ADDR/ENDP/CRC5 capture, verdict pulse.
// Latency: verdict flag one cycle after eop (len_err one cycle after the fault).
// Backpressure: none; consumes one bit per bit_valid, cannot stall the line.
//
// Optional macro USB_TOKEN_RX_CRC_EN builds the CRC5 checker; without it the
// CRC bits are counted and dropped and crc_err is tied low.
module usb_token_rx
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = USB_SYNC
`ifdef USB_TOKEN_RX_CRC_EN
  ,
  parameter logic [4:0] CRC5_RESIDUAL = USB_CRC5_RESIDUAL
`endif
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       eop,
  input  logic       abort,
  output logic [3:0] pid_out,
  output logic [6:0] addr_out,
  output logic [3:0] endp_out,
  output logic       pkt_valid,
  output logic       pid_err,
  output logic       crc_err,
  output logic       len_err,
  output logic       busy
);

  localparam logic [4:0] PID_LAST  = 5'(PID_BITS - 1);
  localparam logic [4:0] ADDR_LAST = 5'(ADDR_BITS - 1);
  localparam logic [4:0] ENDP_LAST = 5'(ENDP_BITS - 1);
  localparam logic [4:0] CRC_LAST  = 5'(CRC5_BITS - 1);

  tok_state_e state;
  logic [7:0] win;
  logic [7:0] win_nxt;
  logic [4:0] cnt;
  logic [3:0] chk;
  logic       take;
  logic       sync_hit;
  logic       pid_bad;

  // A bit arriving together with eop is dropped; eop decides the cycle.
  assign take     = bit_valid && !eop;
  assign win_nxt  = {bit_in, win[7:1]};
  assign sync_hit = (state == TOK_IDLE) && take && !abort && (win_nxt == SYNC_PATTERN);
  assign busy     = (state != TOK_IDLE);
  assign pid_bad  = (chk != ~pid_out);

`ifdef USB_TOKEN_RX_CRC_EN
  logic [4:0] crc;
  logic       crc_en;
  logic       crc_bad;

  assign crc_en  = take && !abort && (state inside {TOK_ADDR, TOK_ENDP, TOK_CRC});
  assign crc_bad = (crc != CRC5_RESIDUAL);

  usb_crc5 u_crc5 (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr    (sync_hit),
    .en     (crc_en),
    .bit_in (bit_in),
    .crc    (crc)
  );
`else
  assign crc_err = 1'b0;
`endif

  // Token FSM: sync hunt, LSB-first field capture and the end-of-packet verdict.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= TOK_IDLE;
      win       <= 8'h00;
      cnt       <= 5'd0;
      chk       <= 4'h0;
      pid_out   <= 4'h0;
      addr_out  <= 7'h00;
      endp_out  <= 4'h0;
      pkt_valid <= 1'b0;
      pid_err   <= 1'b0;
      len_err   <= 1'b0;
`ifdef USB_TOKEN_RX_CRC_EN
      crc_err   <= 1'b0;
`endif
    end else begin
      pkt_valid <= 1'b0;
      pid_err   <= 1'b0;
      len_err   <= 1'b0;
`ifdef USB_TOKEN_RX_CRC_EN
      crc_err   <= 1'b0;
`endif
      if (abort) begin
        // Flush without a verdict; captured fields keep their last values.
        state <= TOK_IDLE;
        win   <= 8'h00;
        cnt   <= 5'd0;
      end else begin
        case (state)
          TOK_IDLE: begin
            if (take) begin
              win <= win_nxt;
              if (sync_hit) begin
                state <= TOK_PID;
                cnt   <= 5'd0;
              end
            end
          end
          TOK_PID: begin
            if (eop) begin
              len_err <= 1'b1;
              state   <= TOK_IDLE;
            end else if (bit_valid) begin
              if (cnt[2]) chk[cnt[1:0]]     <= bit_in;
              else        pid_out[cnt[1:0]] <= bit_in;
              if (cnt == PID_LAST) begin
                state <= TOK_ADDR;
                cnt   <= 5'd0;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          TOK_ADDR: begin
            if (eop) begin
              len_err <= 1'b1;
              state   <= TOK_IDLE;
            end else if (bit_valid) begin
              addr_out[cnt[2:0]] <= bit_in;
              if (cnt == ADDR_LAST) begin
                state <= TOK_ENDP;
                cnt   <= 5'd0;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          TOK_ENDP: begin
            if (eop) begin
              len_err <= 1'b1;
              state   <= TOK_IDLE;
            end else if (bit_valid) begin
              endp_out[cnt[1:0]] <= bit_in;
              if (cnt == ENDP_LAST) begin
                state <= TOK_CRC;
                cnt   <= 5'd0;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          TOK_CRC: begin
            if (eop) begin
              len_err <= 1'b1;
              state   <= TOK_IDLE;
            end else if (bit_valid) begin
              if (cnt == CRC_LAST) begin
                state <= TOK_WAIT_EOP;
                cnt   <= 5'd0;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
          TOK_WAIT_EOP: begin
            if (eop) begin
              // Exactly one verdict: PID check outranks CRC check.
              state <= TOK_IDLE;
              if (pid_bad) begin
                pid_err <= 1'b1;
              end
`ifdef USB_TOKEN_RX_CRC_EN
              else if (crc_bad) begin
                crc_err <= 1'b1;
              end
`endif
              else begin
                pkt_valid <= 1'b1;
              end
            end else if (bit_valid) begin
              len_err <= 1'b1;
              state   <= TOK_IDLE;
            end
          end
          default: state <= TOK_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_token_rx.sv
// Bench for usb_token_rx: directed vector table, hand-written corner sequences
// and randomized tokens checked against a packet-level reference model.
module tb_usb_token_rx;
  import usb_pkg::*;

  logic       clk;
  logic       rst_b;
  logic       bit_in;
  logic       bit_valid;
  logic       eop;
  logic       abort;
  logic [3:0] pid_out;
  logic [6:0] addr_out;
  logic [3:0] endp_out;
  logic       pkt_valid;
  logic       pid_err;
  logic       crc_err;
  logic       len_err;
  logic       busy;

  usb_token_rx dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .eop       (eop),
    .abort     (abort),
    .pid_out   (pid_out),
    .addr_out  (addr_out),
    .endp_out  (endp_out),
    .pkt_valid (pkt_valid),
    .pid_err   (pid_err),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected verdict encoding {len, crc, pid, pkt}.
  localparam logic [3:0] F_PKT  = 4'b0001;
  localparam logic [3:0] F_PID  = 4'b0010;
  localparam logic [3:0] F_CRC  = 4'b0100;
  localparam logic [3:0] F_LEN  = 4'b1000;
  localparam logic [3:0] F_NONE = 4'b0000;
`ifdef USB_TOKEN_RX_CRC_EN
  localparam logic [3:0] F_BADCRC = F_CRC;
`else
  localparam logic [3:0] F_BADCRC = F_PKT;
`endif

  typedef struct {
    logic [23:0] data;   // PID byte, ADDR, ENDP, CRC field; bit 0 sent first
    int          cut;    // bits sent after SYNC before eop (24 = full token)
    int          extra;  // surplus 0 bits before eop
    int          gaps;   // 0 none, 1 three idle cycles mid-ADDR, 2 random
    logic [3:0]  exp_flags;
    logic [3:0]  exp_pid;
    logic [6:0]  exp_addr;
    logic [3:0]  exp_endp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pkt, n_pid, n_crc, n_len;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // CRC5 field by polynomial long division: first data bit is the highest
  // power, the all-ones preset is added onto the first five data terms, and
  // the inverted remainder is sent most-significant term first.
  function automatic logic [4:0] gen_crc(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] d;
    logic [15:0] p;
    logic [4:0]  f;
    d = {e, a};
    p = 16'h0000;
    for (int i = 0; i < 11; i++) p[15-i] = d[i];
    p[15:11] = p[15:11] ^ 5'h1f;
    for (int k = 15; k >= 5; k--) if (p[k]) p[k -: 6] = p[k -: 6] ^ 6'b100101;
    for (int i = 0; i < 5; i++) f[i] = ~p[4-i];
    return f;
  endfunction

  function automatic logic [23:0] tok(input logic [3:0] pid, input logic [6:0] a,
                                      input logic [3:0] e, input logic [4:0] c);
    return {c, e, a, ~pid, pid};
  endfunction

  function automatic void add_vec(input logic [23:0] data, input int cut, input int extra,
                                  input int gaps, input logic [3:0] fl, input logic [3:0] p,
                                  input logic [6:0] a, input logic [3:0] e);
    vec_t v;
    v.data = data; v.cut = cut; v.extra = extra; v.gaps = gaps;
    v.exp_flags = fl; v.exp_pid = p; v.exp_addr = a; v.exp_endp = e;
    vecs.push_back(v);
  endfunction

  // One clock slot: tally flags produced by the previous edge, then drive.
  task automatic cycle(input logic v, input logic b, input logic e, input logic a);
    @(negedge clk);
    n_pkt += int'(pkt_valid);
    n_pid += int'(pid_err);
    n_crc += int'(crc_err);
    n_len += int'(len_err);
    bit_valid = v;
    bit_in    = b;
    eop       = e;
    abort     = a;
  endtask

  task automatic clear_tally();
    n_pkt = 0; n_pid = 0; n_crc = 0; n_len = 0;
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = USB_SYNC;
    for (int i = 0; i < 8; i++) cycle(1'b1, s[i], 1'b0, 1'b0);
  endtask

  task automatic send_body(input logic [23:0] data, input int cut, input int gaps);
    for (int i = 0; i < cut; i++) begin
      if (gaps == 1 && i == 11) repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (gaps == 2 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, data[i], 1'b0, 1'b0);
    end
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    clear_tally();
    send_sync();
    send_body(v.data, v.cut, v.gaps);
    for (int i = 0; i < v.extra; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, " pkt_valid pulses"}, n_pkt, {31'd0, v.exp_flags[0]});
    check({tag, " pid_err pulses"},   n_pid, {31'd0, v.exp_flags[1]});
    check({tag, " crc_err pulses"},   n_crc, {31'd0, v.exp_flags[2]});
    check({tag, " len_err pulses"},   n_len, {31'd0, v.exp_flags[3]});
    check({tag, " busy after"}, busy, 0);
    if (v.cut == 24) begin
      check({tag, " pid_out"},  pid_out,  v.exp_pid);
      check({tag, " addr_out"}, addr_out, v.exp_addr);
      check({tag, " endp_out"}, endp_out, v.exp_endp);
    end
  endtask

  initial begin
    vec_t v;
    logic [3:0]  codes [4];
    logic [3:0]  p;
    logic [7:0]  b0;
    logic [6:0]  a;
    logic [3:0]  e;
    logic [4:0]  c;
    int          kind;

    codes[0] = PID_OUT; codes[1] = PID_IN; codes[2] = PID_SOF; codes[3] = PID_SETUP;
    rst_b = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; eop = 1'b0; abort = 1'b0;
    clear_tally();

    // Directed table: data, cut, extra, gaps, verdict, pid, addr, endp.
    add_vec(24'h10002D, 24, 0, 0, F_PKT,    4'hD, 7'h00, 4'h0);
    add_vec(24'h10002C, 24, 0, 0, F_PID,    4'hC, 7'h00, 4'h0);
    add_vec(24'h18002D, 24, 0, 0, F_BADCRC, 4'hD, 7'h00, 4'h0);
    add_vec(24'h10002D, 11, 0, 0, F_LEN,    4'hD, 7'h00, 4'h0);
    add_vec(24'h10002D, 24, 0, 0, F_PKT,    4'hD, 7'h00, 4'h0);
    add_vec(24'h10002D, 24, 0, 1, F_PKT,    4'hD, 7'h00, 4'h0);
    add_vec(24'h10002D, 24, 1, 1, F_LEN,    4'hD, 7'h00, 4'h0);
    add_vec(tok(PID_OUT, 7'h15, 4'hE, gen_crc(7'h15, 4'hE)), 24, 0, 0, F_PKT, PID_OUT, 7'h15, 4'hE);
    add_vec(tok(PID_IN, 7'h7F, 4'hF, gen_crc(7'h7F, 4'hF)), 24, 0, 0, F_PKT, PID_IN, 7'h7F, 4'hF);
    add_vec(tok(PID_SOF, 7'h2A, 4'h5, gen_crc(7'h2A, 4'h5)), 24, 0, 0, F_PKT, PID_SOF, 7'h2A, 4'h5);
    add_vec(24'h10002D, 0, 0, 0, F_LEN, 4'hD, 7'h00, 4'h0);
    add_vec(24'h10002D, 23, 0, 0, F_LEN, 4'hD, 7'h00, 4'h0);
    add_vec(tok(PID_SETUP, 7'h01, 4'h0, gen_crc(7'h01, 4'h0) ^ 5'h10), 24, 0, 0, F_BADCRC, PID_SETUP, 7'h01, 4'h0);

    // Reset values while rst_b is held low.
    repeat (3) @(negedge clk);
    check("reset flags", {pkt_valid, pid_err, crc_err, len_err, busy}, 0);
    check("reset fields", {pid_out, addr_out, endp_out}, 0);
    rst_b = 1'b1;

    // eop in IDLE is ignored.
    clear_tally();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle eop flags", n_pkt + n_pid + n_crc + n_len, 0);
    check("idle eop busy", busy, 0);

    for (int i = 0; i < vecs.size(); i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

    // Abort in ENDP: busy drops at once, no verdict, fields keep last bits.
    clear_tally();
    a = 7'h33; e = 4'h6;
    send_sync();
    send_body(tok(PID_OUT, a, e, gen_crc(a, e)), 17, 0);
    check("abort busy before", busy, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort busy after", busy, 0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort flags", n_pkt + n_pid + n_crc + n_len, 0);
    check("abort pid held", pid_out, PID_OUT);
    check("abort addr held", addr_out, a);
    run_pkt(vecs[0], "after abort");

    // Reset mid-CRC clears every output without waiting for a clock edge.
    a = 7'h55; e = 4'hA;
    send_sync();
    send_body(tok(PID_IN, a, e, gen_crc(a, e)), 21, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("midcrc busy", busy, 1);
    check("midcrc addr", addr_out, a);
    #2 rst_b = 1'b0;
    #1;
    check("async reset flags", {pkt_valid, pid_err, crc_err, len_err, busy}, 0);
    check("async reset fields", {pid_out, addr_out, endp_out}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    run_pkt(vecs[0], "after reset");

    // Randomized tokens against the packet-level model.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 4));
      p  = codes[$urandom_range(0, 3)];
      b0 = {~p, p};
      a  = 7'($urandom_range(0, 127));
      e  = 4'($urandom_range(0, 15));
      c  = gen_crc(a, e);
      v.cut = 24; v.extra = 0; v.gaps = 2;
      if (kind == 1) b0[4 + $urandom_range(0, 3)] ^= 1'b1;
      if (kind == 2) c[$urandom_range(0, 4)] ^= 1'b1;
      if (kind == 3) v.cut = int'($urandom_range(0, 23));
      if (kind == 4) v.extra = int'($urandom_range(1, 3));
      v.data = {c, e, a, b0};
      if (v.cut < 24 || v.extra > 0)   v.exp_flags = F_LEN;
      else if (b0[7:4] != ~b0[3:0])    v.exp_flags = F_PID;
      else if (c != gen_crc(a, e))     v.exp_flags = F_BADCRC;
      else                             v.exp_flags = F_PKT;
      v.exp_pid = b0[3:0]; v.exp_addr = a; v.exp_endp = e;
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      run_pkt(v, $sformatf("rand%0d", n));
    end

    if (F_NONE != 4'b0000) n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
